// File: rtl/res_ctl_pkg.sv
// Shared types for the reset conditioner: FSM state encoding and the
// reset-cause codes reported to firmware.
package res_ctl_pkg;

  typedef enum logic [1:0] {
    ST_PIN   = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_SWRES = 2'd3
  } state_t;

  // Code 3 is reserved and never produced.
  typedef enum logic [1:0] {
    CAUSE_PIN  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_SW   = 2'd2
  } cause_t;

endpackage

// File: rtl/res_ctl_if.sv
// Signal bundle between the board/config side and the reset conditioner.
//   pll_locked : PLL lock indicator (asynchronous to clk_cog)
//   sw_res     : software reset request, synchronous level
//   nres       : conditioned active-low core reset
//   res_cause  : cause of the most recent reset
//   res_busy   : high whenever the conditioner is not in RUN
// master = board/config side, slave = res_ctl.
interface res_ctl_if;
  import res_ctl_pkg::*;

  logic   pll_locked;
  logic   sw_res;
  logic   nres;
  cause_t res_cause;
  logic   res_busy;

  modport master (
    output pll_locked, sw_res,
    input  nres, res_cause, res_busy
  );

  modport slave (
    input  pll_locked, sw_res,
    output nres, res_cause, res_busy
  );
endinterface

// File: rtl/res_ctl_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear.
//   clk_cog : destination clock
//   clr_n   : asynchronous clear, output reads 0 while low
//   d_i     : asynchronous input
//   q_o     : synchronised output, two clk_cog edges behind d_i
module sync2 (
  input  logic clk_cog,
  input  logic clr_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_cog or negedge clr_n) begin
    if (!clr_n) ff_q <= 2'b00;
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/res_ctl.sv
// Reset conditioner between the board reset pin, the PLL lock indicator and
// the core's nres input. Debounces pin release, waits for a stable PLL lock,
// stretches software reset requests and records the last reset cause.
//   clk_cog  : single clock
//   inp_resn : async active-low board reset (release synchronised internally)
//   bus      : res_ctl_if slave (pll_locked, sw_res in; nres, res_cause,
//              res_busy out, all outputs registered)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PIN   | pin reset / power-on; debounce pin_ok & lock_s for DEB_CYC
// ST_RUN   | core running, nres high
// ST_LOCK  | lock lost; wait for LOCK_CYC consecutive locked cycles
// ST_SWRES | software reset pulse of SW_CYC cycles
module res_ctl
  import res_ctl_pkg::*;
#(
  parameter logic [15:0] DEB_CYC  = 16'd50000,
  parameter logic [15:0] LOCK_CYC = 16'd1000,
  parameter logic [7:0]  SW_CYC   = 8'd16,
  parameter int          CNT_W    = 16
) (
  input  logic      clk_cog,
  input  logic      inp_resn,
  res_ctl_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_LD  = CNT_W'(DEB_CYC - 16'd1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYC - 16'd1);
  localparam logic [CNT_W-1:0] SW_LD   = CNT_W'(SW_CYC - 8'd1);

  logic pin_ok;
  logic lock_s;

  // Pin chain samples a constant 1: it only delays the release of inp_resn.
  sync2 u_sync_pin (
    .clk_cog (clk_cog),
    .clr_n   (inp_resn),
    .d_i     (1'b1),
    .q_o     (pin_ok)
  );

  sync2 u_sync_lock (
    .clk_cog (clk_cog),
    .clr_n   (inp_resn),
    .d_i     (bus.pll_locked),
    .q_o     (lock_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cause_t           cause_q, cause_d;
  logic             nres_q, nres_d;
  logic             busy_q, busy_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_PIN: begin
        if (!(pin_ok && lock_s)) cnt_d = DEB_LD;
        else if (cnt_zero)       state_d = ST_RUN;
        else                     cnt_d = cnt_q - CNT_W'(1);
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous software request.
        if (!lock_s) begin
          state_d = ST_LOCK;
          cnt_d   = LOCK_LD;
          cause_d = CAUSE_LOCK;
        end else if (bus.sw_res) begin
          state_d = ST_SWRES;
          cnt_d   = SW_LD;
          cause_d = CAUSE_SW;
        end
      end
      ST_LOCK: begin
        if (!lock_s)       cnt_d = LOCK_LD;
        else if (cnt_zero) state_d = ST_RUN;
        else               cnt_d = cnt_q - CNT_W'(1);
      end
      ST_SWRES: begin
        // sw_res is ignored here: the core clears it while held in reset.
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (lock_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOCK;
          cnt_d   = LOCK_LD;
          cause_d = CAUSE_LOCK;
        end
      end
      default: begin
        state_d = ST_PIN;
        cnt_d   = DEB_LD;
      end
    endcase
    // Outputs decode the next state so they switch together with the state.
    nres_d = (state_d == ST_RUN);
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_cog or negedge inp_resn) begin
    if (!inp_resn) begin
      state_q <= ST_PIN;
      cnt_q   <= DEB_LD;
      cause_q <= CAUSE_PIN;
      nres_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      nres_q  <= nres_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.nres      = nres_q;
  assign bus.res_cause = cause_q;
  assign bus.res_busy  = busy_q;

endmodule
